// File: rtl/shared_net_arbiter.sv
// rtl/shared_net_arbiter.sv - round-robin owner of a shared resolved net with hold timeout and Z turnaround
module shared_net_arbiter #(
    parameter int N_REQ      = 4,
    parameter int W          = 8,
    parameter int MAX_HOLD   = 15,
    parameter int TURNAROUND = 1,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0][W-1:0]   drv_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      bus_oe,
    output logic [W-1:0]              bus_data,
    output logic [IDW-1:0]            owner_id,
    output logic                      timeout,
    output logic [IDW-1:0]            timeout_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [7:0]       hold_q, hold_d;
    logic [2:0]       turn_q, turn_d;
    logic             timeout_q, timeout_d;
    logic [IDW-1:0]   tid_q, tid_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   ptr_after_owner;
    int               scan_idx;

    // First asserted request at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        if (owner_q == IDW'(N_REQ - 1)) begin
            ptr_after_owner = '0;
        end else begin
            ptr_after_owner = owner_q + IDW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        timeout_d = 1'b0;
        tid_d     = tid_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d          = S_GRANT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    hold_d           = 8'd1;
                end
            end
            S_GRANT: begin
                if (!req[owner_q] || hold_q == 8'(MAX_HOLD)) begin
                    // Still requesting at the limit means the release is forced.
                    timeout_d = req[owner_q];
                    if (req[owner_q]) begin
                        tid_d = owner_q;
                    end
                    state_d = S_TURN;
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                    turn_d  = 3'(TURNAROUND);
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_TURN: begin
                turn_d = turn_q - 3'd1;
                if (turn_q == 3'd1) begin
                    if (win_found) begin
                        state_d          = S_GRANT;
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        owner_d          = win_idx;
                        hold_d           = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            timeout_q <= 1'b0;
            tid_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            timeout_q <= timeout_d;
            tid_q     <= tid_d;
        end
    end

    assign grant      = grant_q;
    assign bus_oe     = |grant_q;
    assign bus_data   = bus_oe ? drv_data[owner_q] : {W{1'bz}};
    assign owner_id   = owner_q;
    assign timeout    = timeout_q;
    assign timeout_id = tid_q;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// tb/tb_shared_net_arbiter.sv - directed scoreboard bench for shared_net_arbiter
module tb_shared_net_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [3:0][7:0]  drv_data;
    wire  [3:0]       grant;
    wire              bus_oe;
    wire  [7:0]       bus_data;
    wire  [1:0]       owner_id;
    wire              timeout;
    wire  [1:0]       timeout_id;

    shared_net_arbiter #(
        .N_REQ(4), .W(8), .MAX_HOLD(4), .TURNAROUND(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .drv_data(drv_data),
        .grant(grant), .bus_oe(bus_oe), .bus_data(bus_data),
        .owner_id(owner_id), .timeout(timeout), .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [7:0] d;
        logic       to;
        logic [1:0] tid;
        logic [1:0] own;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: got %h want %h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [7:0] data_of(input logic [3:0] g);
        case (g)
            4'b0001: return drv_data[0];
            4'b0010: return drv_data[1];
            4'b0100: return drv_data[2];
            4'b1000: return drv_data[3];
            default: return 8'h00;
        endcase
    endfunction

    task automatic push(input string tag, input logic [3:0] g, input logic to, input logic [1:0] tid, input logic [1:0] own);
        exp_t e;
        e.tag = tag; e.g = g; e.d = data_of(g); e.to = to; e.tid = tid; e.own = own;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue want an entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "grant", {4'h0, grant}, {4'h0, e.g});
            chk(e.tag, "bus_oe", {7'h0, bus_oe}, {7'h0, |e.g});
            if (e.g != 4'b0000) begin
                chk(e.tag, "bus_data", bus_data, e.d);
            end
            chk(e.tag, "timeout", {7'h0, timeout}, {7'h0, e.to});
            if (e.to) begin
                chk(e.tag, "timeout_id", {6'h0, timeout_id}, {6'h0, e.tid});
            end
            chk(e.tag, "owner_id", {6'h0, owner_id}, {6'h0, e.own});
        end
    endtask

    // Drive req for the next edge, record what must appear after it, then check mid-cycle.
    task automatic step(input logic [3:0] r, input string tag, input logic [3:0] g,
                        input logic to, input logic [1:0] tid, input logic [1:0] own);
        req = r;
        push(tag, g, to, tid, own);
        @(posedge clk);
        @(negedge clk);
        compare_head();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        drv_data = {8'h43, 8'hA5, 8'h21, 8'h10};

        @(negedge clk);
        push("reset", 4'b0000, 1'b0, 2'd0, 2'd0);
        compare_head();
        chk("reset", "timeout_id", {6'h0, timeout_id}, 8'h00);
        rst = 1'b0;

        // single request, voluntary drop after 3 cycles, 2-cycle gap, then idle
        step(4'b0100, "s1_g0", 4'b0100, 1'b0, 2'd0, 2'd2);
        step(4'b0100, "s1_g1", 4'b0100, 1'b0, 2'd0, 2'd2);
        step(4'b0100, "s1_g2", 4'b0100, 1'b0, 2'd0, 2'd2);
        step(4'b0000, "s1_z0", 4'b0000, 1'b0, 2'd0, 2'd2);
        step(4'b0000, "s1_z1", 4'b0000, 1'b0, 2'd0, 2'd2);
        step(4'b0000, "s1_idle0", 4'b0000, 1'b0, 2'd0, 2'd2);
        step(4'b0000, "s1_idle1", 4'b0000, 1'b0, 2'd0, 2'd2);

        // wrap-around: ptr=3, index 0 beats index 1
        step(4'b0011, "s4_g0", 4'b0001, 1'b0, 2'd0, 2'd0);
        step(4'b0010, "s4_z0", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0010, "s4_z1", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0010, "s4_g1", 4'b0010, 1'b0, 2'd0, 2'd1);

        // non-owner request mid-tenure has no effect until owner drops
        step(4'b1010, "s3_hold0", 4'b0010, 1'b0, 2'd0, 2'd1);
        step(4'b1010, "s3_hold1", 4'b0010, 1'b0, 2'd0, 2'd1);
        step(4'b1000, "s3_z0", 4'b0000, 1'b0, 2'd0, 2'd1);
        step(4'b1000, "s3_z1", 4'b0000, 1'b0, 2'd0, 2'd1);
        step(4'b1000, "s3_g3", 4'b1000, 1'b0, 2'd0, 2'd3);
        step(4'b0000, "s3_z2", 4'b0000, 1'b0, 2'd0, 2'd3);
        step(4'b0000, "s3_z3", 4'b0000, 1'b0, 2'd0, 2'd3);
        step(4'b0000, "s3_idle", 4'b0000, 1'b0, 2'd0, 2'd3);

        // all requesting: 0,1,2,3,0 with forced releases
        for (int k = 0; k < 5; k++) begin
            logic [1:0] idx;
            logic [3:0] g;
            idx = 2'(k % 4);
            g   = 4'b0001 << idx;
            for (int h = 0; h < 4; h++) begin
                step(4'b1111, "s2_hold", g, 1'b0, 2'd0, idx);
            end
            step(4'b1111, "s2_to", 4'b0000, 1'b1, idx, idx);
            step((k == 4) ? 4'b0000 : 4'b1111, "s2_gap", 4'b0000, 1'b0, 2'd0, idx);
        end
        step(4'b0000, "s2_idle", 4'b0000, 1'b0, 2'd0, 2'd0);

        // data tracking: ptr=1, only driver 0 requests
        drv_data[0] = 8'h3C;
        step(4'b0001, "s6_g0", 4'b0001, 1'b0, 2'd0, 2'd0);
        drv_data[0] = 8'hC3;
        #1;
        push("s6_live", 4'b0001, 1'b0, 2'd0, 2'd0);
        compare_head();
        step(4'b0001, "s6_g1", 4'b0001, 1'b0, 2'd0, 2'd0);
        step(4'b0000, "s6_z0", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0000, "s6_z1", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0000, "s6_idle", 4'b0000, 1'b0, 2'd0, 2'd0);

        // reset in the middle of a tenure
        step(4'b0010, "s5_g0", 4'b0010, 1'b0, 2'd0, 2'd1);
        step(4'b0010, "s5_g1", 4'b0010, 1'b0, 2'd0, 2'd1);
        rst = 1'b1;
        #1;
        push("s5_rst", 4'b0000, 1'b0, 2'd0, 2'd0);
        compare_head();
        #1;
        rst = 1'b0;
        step(4'b0010, "s5_regrant", 4'b0010, 1'b0, 2'd0, 2'd1);
        step(4'b0000, "s5_z0", 4'b0000, 1'b0, 2'd0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
